// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver. It decodes a packed hex word and scans the digits,
// with an anode guard band, leading-zero blanking and double-buffered frame-synchronous update.
module seven_seg_mux #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned AN_ACTIVE_LOW  = 1,
    parameter int unsigned LZ_BLANK       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic                    pending_q, pending_d;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    tick, frame_tick;
    logic                    zero_run, in_blank;
    logic [NUM_DIGITS-1:0]   lz_off, an_sel;
    logic [3:0]              cur_code;
    logic                    cur_dp, cur_off;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'b1111110;
            4'h1:    decode = 7'b0110000;
            4'h2:    decode = 7'b1101101;
            4'h3:    decode = 7'b1111001;
            4'h4:    decode = 7'b0110011;
            4'h5:    decode = 7'b1011011;
            4'h6:    decode = 7'b1011111;
            4'h7:    decode = 7'b1110000;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1110011;
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b0011111;
            4'hC:    decode = 7'b1001110;
            4'hD:    decode = 7'b0111101;
            4'hE:    decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    assign tick       = enable && (cnt_q == CntLast);
    assign frame_tick = tick && (idx_q == IdxLast);

    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        pending_d = pending_q;

        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (load) begin
            sh_val_d  = value;
            sh_dp_d   = dp_in;
            sh_en_d   = digit_en;
            pending_d = 1'b1;
        end

        // Active set only changes between frames (or while dark); a same-cycle load wins.
        if (!enable || frame_tick) begin
            if (load) begin
                act_val_d = value;
                act_dp_d  = dp_in;
                act_en_d  = digit_en;
                pending_d = 1'b0;
            end else if (pending_q) begin
                act_val_d = sh_val_q;
                act_dp_d  = sh_dp_q;
                act_en_d  = sh_en_q;
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        zero_run = 1'b1;
        lz_off   = '0;
        an_sel   = '0;
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_off  = 1'b0;
        seg_d    = '0;
        dp_d     = 1'b0;
        an_d     = '0;

        // Walk from the most significant digit down while every digit so far is zero.
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run  = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            lz_off[i] = (LZ_BLANK != 0) && (i != 0) && zero_run;
        end

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                an_sel[i] = 1'b1;
                cur_code  = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_off   = !act_en_q[i] || lz_off[i];
            end
        end

        in_blank = (32'(cnt_q) < BLANK_CYCLES);

        if (enable && !in_blank) begin
            an_d = an_sel;
            if (!cur_off) begin
                seg_d = decode(cur_code);
                dp_d  = cur_dp;
            end
        end

        frame_d = frame_tick;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_en_q  <= '0;
            pending_q <= 1'b0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            an_q      <= '0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_en_q   <= sh_en_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_en_q  <= act_en_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign seg   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp    = (SEG_ACTIVE_LOW != 0) ? ~dp_q : dp_q;
    assign an    = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
    assign frame = frame_q;

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus.
- Decodes a packed hex word (4 bits per digit) and scans digits at a programmable rate.
- Adds anode-off ghosting guard, leading-zero blanking, per-digit decimal points and tear-free frame-synchronous value update.
- Sits between core status registers and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clk cycles each digit slot lasts (>=2).
- BLANK_CYCLES, 2, cycles at start of each slot with anodes inactive (0..REFRESH_DIV-1).
- SEG_ACTIVE_LOW, 0, 1 = seg/dp pins driven low when lit.
- AN_ACTIVE_LOW, 1, 1 = an pins driven low when selected.
- LZ_BLANK, 1, 1 = enable leading-zero blanking.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  1 = scanning on; 0 = display dark, scan held.
- load  in  1  capture value/dp_in/digit_en into shadow registers this cycle.
- value  in  4*NUM_DIGITS  hex digits; value[3:0] = digit 0 (rightmost).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- digit_en  in  NUM_DIGITS  per-digit force-blank (0 = blank).
- seg  out  7  seg[6]=a ... seg[0]=g, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, same polarity as seg.
- an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW.
- frame  out  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on rising edge of clk).
- Reset: prescaler=0, index=0, shadow/active regs=0, pending=0; an, seg, dp all inactive; frame=0.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1; tick when count==REFRESH_DIV-1, then wraps to 0; index advances on tick, NUM_DIGITS-1 wraps to 0.
- frame=1 in the cycle after the tick where index was NUM_DIGITS-1.
- Decode (logical, a..g): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1110011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111. All 16 codes defined, no X.
- Outputs registered; 1-cycle latency from index/count to pins.
- Slot: for count<BLANK_CYCLES, an all inactive; otherwise an selects index, seg/dp show active digit.
- Digit blanked (seg and dp inactive, an still asserted) if active digit_en[i]=0, or LZ_BLANK=1 and all digits i..NUM_DIGITS-1 are zero and i!=0. Digit 0 never LZ-blanked. dp follows active dp_in[i] unless digit_en[i]=0.
- Double buffer: load writes shadow, sets pending. On the frame-boundary tick, active<=shadow, pending<=0. If load coincides with that tick, inputs go directly to active and pending stays 0 (new value wins).
- enable=0: prescaler=0, index=0, outputs inactive next cycle, frame=0; pending shadow copied to active immediately. Re-enable starts slot 0 at count 0.
- rst_n low mid-scan overrides everything incl. load; outputs inactive next cycle.
- Polarity inversion is applied last, to registered outputs only.

Test Plan:
- Reset/idle: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0; hold rst_n=0 3 cycles -> an=4'b1111, seg=0, dp=0, frame=0.
- Scan order/timing: load value=16'h12AF, enable=1 -> per 4-cycle slot: 1 cycle an=1111, then 3 cycles an=1110 seg=1000111 (F); next slots 1101/1110111, 1011/1101101, 0111/0110000; frame pulses once every 16 cycles.
- Tear-free update: load 16'h0003 mid-frame while showing 16'h12AF -> remaining slots keep 12AF; after frame pulse digit0=1111001, digits1..3 LZ-blanked (seg=0 with an asserted).
- Coincident load and frame tick: load 16'h8888 in the tick cycle -> next frame shows seg=1111111 on all digits, no intervening old frame.
- Masks/dp: digit_en=4'b1011, dp_in=4'b0100, value=16'h5555 -> digit2 blank (seg=0, dp=0), digits 0,1,3 seg=1011011, dp=0; with dp_in=4'b0010 digit1 dp=1.
- Enable drop/reset mid-scan: enable=0 during digit 2 -> next cycle an=1111, seg=0; re-enable -> slot 0 starts fresh. rst_n=0 with load=1 -> shadow stays 0, outputs inactive.
